// File: rtl/mem_wb_pipe_if.sv
// Data-memory request/ack bus between the MEM stage and the data memory.
// Combinational bundle; the request side holds every field stable until ack.
// The memory stretches an access simply by withholding dmem_ack.
interface mem_wb_pipe_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM stage: EX/MEM register, data-memory handshake FSM, MEM/WB register (MEM_TIMEOUT_EN adds a WAIT timeout).
// Latency: 1 cycle for non-memory ops, 2+ cycles for loads/stores (WAIT until ack, then DONE).
// Backpressure: mem_busy holds EX/MEM and stalls upstream while in WAIT; WB receives bubbles meanwhile.
module mem_wb_pipe #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [4:0]         ex_rf_wa,
    input  logic               ex_rf_we,
    input  logic [1:0]         ex_rf_wd_sel,
    input  logic [31:0]        ex_alu_res,
    input  logic [31:0]        ex_pc_add4,
    input  logic               ex_mem_re,
    input  logic               ex_mem_we,
    input  logic [31:0]        ex_dmem_wd,
    mem_wb_pipe_if.master      bus,
    output logic               mem_busy,
    output logic [4:0]         mem_rf_wa,
    output logic               mem_rf_we,
    output logic [1:0]         mem_rf_wd_sel,
    output logic [31:0]        dmem_rd_out,
    output logic [4:0]         wb_rf_wa,
    output logic               wb_rf_we,
    output logic [31:0]        wb_rf_wd,
    output logic               mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic [31:0] alu_res_q;
    logic [31:0] pc_add4_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [31:0] dmem_wd_q;

    logic in_wait;
    logic ex_is_mem;
    logic ack_hit;
    logic to_hit;
    logic wb_ok;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign in_wait   = (state == S_WAIT);
    assign ex_is_mem = ex_valid & (ex_mem_re | ex_mem_we);
    assign ack_hit   = in_wait & bus.dmem_ack;

    assign mem_busy       = in_wait;
    assign bus.dmem_req   = in_wait;
    assign bus.dmem_we    = in_wait & mem_we_q;
    assign bus.dmem_addr  = in_wait ? alu_res_q : 32'h0;
    assign bus.dmem_wdata = in_wait ? dmem_wd_q : 32'h0;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] to_cnt;
    logic          aborted;
    logic          err_q;

    assign to_hit = in_wait & ~bus.dmem_ack & (to_cnt == CW'(TIMEOUT - 1));

    // DONE lasts exactly one cycle, so aborted marks precisely the aborted instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            aborted <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            to_cnt  <= (in_wait && !bus.dmem_ack && !to_hit) ? to_cnt + 1'b1 : '0;
            aborted <= to_hit;
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign wb_ok   = ~aborted;
    assign mem_err = err_q;
`else
    assign to_hit  = 1'b0;
    assign wb_ok   = 1'b1;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mem_rf_wa     <= '0;
            mem_rf_we     <= 1'b0;
            mem_rf_wd_sel <= '0;
            alu_res_q     <= '0;
            pc_add4_q     <= '0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            dmem_wd_q     <= '0;
            dmem_rd_out   <= '0;
            wb_rf_wa      <= '0;
            wb_rf_we      <= 1'b0;
            wb_rf_wd      <= '0;
        end else begin
            case (state)
                S_IDLE:  state <= ex_is_mem ? S_WAIT : S_IDLE;
                S_WAIT:  if (ack_hit || to_hit) state <= S_DONE;
                S_DONE:  state <= ex_is_mem ? S_WAIT : S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (!mem_busy) begin
                mem_rf_wa     <= ex_valid ? ex_rf_wa     : 5'd0;
                mem_rf_we     <= ex_valid & ex_rf_we;
                mem_rf_wd_sel <= ex_valid ? ex_rf_wd_sel : 2'd0;
                alu_res_q     <= ex_valid ? ex_alu_res   : 32'h0;
                pc_add4_q     <= ex_valid ? ex_pc_add4   : 32'h0;
                mem_re_q      <= ex_valid & ex_mem_re;
                mem_we_q      <= ex_valid & ex_mem_we;
                dmem_wd_q     <= ex_valid ? ex_dmem_wd   : 32'h0;
            end

            // Store wins when both re and we are set: nothing is captured.
            if (ack_hit && mem_re_q && !mem_we_q)
                dmem_rd_out <= bus.dmem_rdata;

            if (mem_busy) begin
                wb_rf_wa <= '0;
                wb_rf_we <= 1'b0;
                wb_rf_wd <= '0;
            end else begin
                wb_rf_wa <= mem_rf_wa;
                wb_rf_we <= mem_rf_we & (mem_rf_wa != 5'd0) & wb_ok;
                case (mem_rf_wd_sel)
                    2'b00:   wb_rf_wd <= alu_res_q;
                    2'b01:   wb_rf_wd <= dmem_rd_out;
                    2'b10:   wb_rf_wd <= pc_add4_q;
                    default: wb_rf_wd <= 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: ALU, load/store handshake, x0, select mux, reset mid-WAIT, timeout.
module tb_mem_wb_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rf_wa;
    logic        ex_rf_we;
    logic [1:0]  ex_rf_wd_sel;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_pc_add4;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [31:0] ex_dmem_wd;
    logic        mem_busy;
    logic [4:0]  mem_rf_wa;
    logic        mem_rf_we;
    logic [1:0]  mem_rf_wd_sel;
    logic [31:0] dmem_rd_out;
    logic [4:0]  wb_rf_wa;
    logic        wb_rf_we;
    logic [31:0] wb_rf_wd;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    mem_wb_pipe_if bus();

    mem_wb_pipe #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_rf_wa      (ex_rf_wa),
        .ex_rf_we      (ex_rf_we),
        .ex_rf_wd_sel  (ex_rf_wd_sel),
        .ex_alu_res    (ex_alu_res),
        .ex_pc_add4    (ex_pc_add4),
        .ex_mem_re     (ex_mem_re),
        .ex_mem_we     (ex_mem_we),
        .ex_dmem_wd    (ex_dmem_wd),
        .bus           (bus.master),
        .mem_busy      (mem_busy),
        .mem_rf_wa     (mem_rf_wa),
        .mem_rf_we     (mem_rf_we),
        .mem_rf_wd_sel (mem_rf_wd_sel),
        .dmem_rd_out   (dmem_rd_out),
        .wb_rf_wa      (wb_rf_wa),
        .wb_rf_we      (wb_rf_we),
        .wb_rf_wd      (wb_rf_wd),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [4:0] wa, input logic we, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4,
                          input logic re, input logic mwe, input logic [31:0] wd);
        ex_valid = v; ex_rf_wa = wa; ex_rf_we = we; ex_rf_wd_sel = sel;
        ex_alu_res = alu; ex_pc_add4 = pc4; ex_mem_re = re; ex_mem_we = mwe; ex_dmem_wd = wd;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        clear_ex();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  32'(mem_busy),     32'h0);
        chk("rst_req",   32'(bus.dmem_req), 32'h0);
        chk("rst_wb_we", 32'(wb_rf_we),     32'h0);
        chk("rst_rd",    dmem_rd_out,       32'h0);
        chk("rst_err",   32'(mem_err),      32'h0);

        // ALU op
        set_ex(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        clear_ex();
        chk("alu_mem_wa",   32'(mem_rf_wa), 32'd5);
        chk("alu_mem_we",   32'(mem_rf_we), 32'h1);
        chk("alu_busy",     32'(mem_busy),  32'h0);
        tick();
        chk("alu_wb_we", 32'(wb_rf_we), 32'h1);
        chk("alu_wb_wa", 32'(wb_rf_wa), 32'd5);
        chk("alu_wb_wd", wb_rf_wd,      32'h1234);

        // Load with ack in the third WAIT cycle
        set_ex(1'b1, 5'd7, 1'b1, 2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        clear_ex();
        chk("ld_w1_req",  32'(bus.dmem_req), 32'h1);
        chk("ld_w1_addr", bus.dmem_addr,     32'h100);
        chk("ld_w1_busy", 32'(mem_busy),     32'h1);
        chk("ld_w1_we",   32'(bus.dmem_we),  32'h0);
        chk("ld_w1_wb",   32'(wb_rf_we),     32'h0);
        tick();
        chk("ld_w2_req",  32'(bus.dmem_req), 32'h1);
        chk("ld_w2_wb",   32'(wb_rf_we),     32'h0);
        tick();
        chk("ld_w3_req",  32'(bus.dmem_req), 32'h1);
        chk("ld_w3_addr", bus.dmem_addr,     32'h100);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("ld_done_req",  32'(bus.dmem_req), 32'h0);
        chk("ld_done_busy", 32'(mem_busy),     32'h0);
        chk("ld_done_rd",   dmem_rd_out,       32'hDEADBEEF);
        chk("ld_done_wb",   32'(wb_rf_we),     32'h0);
        tick();
        chk("ld_wb_wa", 32'(wb_rf_wa), 32'd7);
        chk("ld_wb_we", 32'(wb_rf_we), 32'h1);
        chk("ld_wb_wd", wb_rf_wd,      32'hDEADBEEF);

        // Stray ack outside WAIT
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BAD0BAD;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("stray_rd",   dmem_rd_out,   32'hDEADBEEF);
        chk("stray_busy", 32'(mem_busy), 32'h0);

        // Store (ack first WAIT cycle) followed directly by a load
        set_ex(1'b1, 5'd0, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, 1'b1, 32'h55);
        tick();
        chk("st_we",    32'(bus.dmem_we),  32'h1);
        chk("st_req",   32'(bus.dmem_req), 32'h1);
        chk("st_addr",  bus.dmem_addr,     32'h40);
        chk("st_wdata", bus.dmem_wdata,    32'h55);
        bus.dmem_ack = 1'b1;
        set_ex(1'b1, 5'd9, 1'b1, 2'b01, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        bus.dmem_ack = 1'b0;
        chk("st_done_we",   32'(bus.dmem_we),  32'h0);
        chk("st_done_req",  32'(bus.dmem_req), 32'h0);
        chk("st_done_busy", 32'(mem_busy),     32'h0);
        tick();
        clear_ex();
        chk("st_wb_we",    32'(wb_rf_we),     32'h0);
        chk("ld2_req",     32'(bus.dmem_req), 32'h1);
        chk("ld2_addr",    bus.dmem_addr,     32'h80);
        chk("ld2_we",      32'(bus.dmem_we),  32'h0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("ld2_rd", dmem_rd_out, 32'hCAFEF00D);
        tick();
        chk("ld2_wb_wa", 32'(wb_rf_wa), 32'd9);
        chk("ld2_wb_wd", wb_rf_wd,      32'hCAFEF00D);

        // re and we both set: store wins, no capture
        set_ex(1'b1, 5'd3, 1'b1, 2'b01, 32'h10, 32'h0, 1'b1, 1'b1, 32'h77);
        tick();
        clear_ex();
        chk("both_we", 32'(bus.dmem_we), 32'h1);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h11111111;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("both_rd", dmem_rd_out, 32'hCAFEF00D);
        tick();
        chk("both_wb_wd", wb_rf_wd, 32'hCAFEF00D);

        // x0 destination
        set_ex(1'b1, 5'd0, 1'b1, 2'b00, 32'h999, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        clear_ex();
        chk("x0_mem_we", 32'(mem_rf_we), 32'h1);
        tick();
        chk("x0_wb_we", 32'(wb_rf_we), 32'h0);

        // pc+4 and reserved selects, pipelined back-to-back
        set_ex(1'b1, 5'd1, 1'b1, 2'b10, 32'h5, 32'h2004, 1'b0, 1'b0, 32'h0);
        tick();
        set_ex(1'b1, 5'd2, 1'b1, 2'b11, 32'h5, 32'h2008, 1'b0, 1'b0, 32'h0);
        tick();
        chk("pc4_wb_wd", wb_rf_wd, 32'h2004);
        set_ex(1'b0, 5'd4, 1'b1, 2'b00, 32'hAAAA, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("rsv_wb_wd",     wb_rf_wd,         32'h0);
        chk("rsv_wb_we",     32'(wb_rf_we),    32'h1);
        chk("bubble_mem_we", 32'(mem_rf_we),   32'h0);
        chk("bubble_mem_wa", 32'(mem_rf_wa),   32'h0);
        chk("bubble_req",    32'(bus.dmem_req), 32'h0);
        clear_ex();
        tick();

        // Unanswered load: timeout abort, or indefinite wait
        set_ex(1'b1, 5'd6, 1'b1, 2'b01, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        clear_ex();
`ifdef MEM_TIMEOUT_EN
        tick(); tick(); tick();
        chk("to_w4_req", 32'(bus.dmem_req), 32'h1);
        chk("to_w4_err", 32'(mem_err),      32'h0);
        tick();
        chk("to_req",  32'(bus.dmem_req), 32'h0);
        chk("to_busy", 32'(mem_busy),     32'h0);
        chk("to_err",  32'(mem_err),      32'h1);
        tick();
        chk("to_wb_we", 32'(wb_rf_we), 32'h0);
        tick();
        chk("to_err_sticky", 32'(mem_err), 32'h1);
`else
        repeat (10) tick();
        chk("nto_req",  32'(bus.dmem_req), 32'h1);
        chk("nto_busy", 32'(mem_busy),     32'h1);
        chk("nto_err",  32'(mem_err),      32'h0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h600D;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        tick();
        chk("nto_wb_we", 32'(wb_rf_we), 32'h1);
        chk("nto_wb_wd", wb_rf_wd,      32'h600D);
`endif

        // Reset during WAIT, then a late ack
        set_ex(1'b1, 5'd8, 1'b1, 2'b01, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        clear_ex();
        chk("rw_req", 32'(bus.dmem_req), 32'h1);
        rst = 1'b1;
        tick();
        chk("rw_req_drop", 32'(bus.dmem_req), 32'h0);
        tick();
        rst = 1'b0;
        chk("rw_busy",   32'(mem_busy),  32'h0);
        chk("rw_rd",     dmem_rd_out,    32'h0);
        chk("rw_wb_wd",  wb_rf_wd,       32'h0);
        chk("rw_mem_wa", 32'(mem_rf_wa), 32'h0);
        chk("rw_err",    32'(mem_err),   32'h0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF;
        tick();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        chk("rw_ack_rd",  dmem_rd_out,       32'h0);
        chk("rw_ack_req", 32'(bus.dmem_req), 32'h0);
        set_ex(1'b1, 5'd10, 1'b1, 2'b00, 32'hAB, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        clear_ex();
        chk("rw_alu_busy", 32'(mem_busy), 32'h0);
        tick();
        chk("rw_alu_wd", wb_rf_wd, 32'hAB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- MEM stage of the 5-stage pipelined CPU: the EX/MEM segment register, a variable-latency data-memory handshake FSM, and the MEM/WB segment register.
- Directly feeds the data forwarding unit: mem_rf_wa, mem_rf_we, mem_rf_wd_sel, dmem_rd_out, wb_rf_wa, wb_rf_we, wb_rf_wd. The WB-stage outputs also drive the register-file write port.
- Asserts mem_busy to freeze IF/ID/EX while a memory access is outstanding.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_rf_wa  in  5  destination register.
- ex_rf_we  in  1  register write enable.
- ex_rf_wd_sel  in  2  writeback select: 00 ALU, 01 dmem, 10 pc+4, 11 reserved (writes 0).
- ex_alu_res  in  32  ALU result / memory address.
- ex_pc_add4  in  32  pc+4.
- ex_mem_re  in  1  load.
- ex_mem_we  in  1  store.
- ex_dmem_wd  in  32  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  memory write.
- dmem_addr  out  32  memory address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  access complete; rdata valid this cycle.
- dmem_rdata  in  32  load data.
- mem_busy  out  1  stall request to upstream stages.
- mem_rf_wa  out  5  MEM-stage destination register.
- mem_rf_we  out  1  MEM-stage write enable (gated by valid).
- mem_rf_wd_sel  out  2  MEM-stage writeback select.
- dmem_rd_out  out  32  captured load data.
- wb_rf_wa  out  5  WB-stage destination register.
- wb_rf_we  out  1  WB-stage write enable.
- wb_rf_wd  out  32  WB-stage write data.
- mem_err  out  1  sticky timeout flag (0 when feature absent).

Behaviour:
- Reset: all registers and outputs 0; FSM IDLE.
- Reset mid-WAIT: FSM returns to IDLE and dmem_req drops the following cycle. Any later ack is ignored.
- FSM states: IDLE, WAIT, DONE.
- EX/MEM register:
  - Loads EX inputs on each edge when mem_busy=0; holds when mem_busy=1.
  - Bubble (all fields 0) when ex_valid=0.
  - mem_rf_we = registered ex_rf_we & ex_valid.
- IDLE -> WAIT: at the same edge that loads a valid instruction with ex_mem_re or ex_mem_we set.
- WAIT:
  - dmem_req=1; dmem_addr=alu_res; dmem_we=mem_we; dmem_wdata=stored data. All held stable until ack.
  - mem_busy=1.
  - On dmem_ack: dmem_rdata latched into dmem_rd_out for loads only; next state DONE.
- DONE:
  - mem_busy=0 and dmem_req=0.
  - Stage advances to WB this edge.
  - Next state: WAIT if the newly loaded instruction is a memory op, else IDLE.
- Minimum load/store occupancy of MEM is 2 cycles (ack in the first WAIT cycle).
- dmem_rd_out holds its value until the next load ack.
- dmem_req=0, dmem_we=0 outside WAIT.
- If mem_re and mem_we are both set, store takes priority and no read data is captured.
- dmem_ack outside WAIT is ignored.
- MEM/WB register, on each edge:
  - If mem_busy=1: WB loads a bubble (wb_rf_we=0, wa=0, wd=0).
  - Otherwise: wb_rf_wa=mem_rf_wa; wb_rf_we=mem_rf_we & (mem_rf_wa!=0); wb_rf_wd = ALU / dmem_rd_out / pc+4 / 0 per sel.
- Writes to x0 never reach WB.
- Non-memory instructions: 1 cycle in MEM, no stall.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With macro:
  - An 8-bit-min counter runs in WAIT.
  - If TIMEOUT cycles elapse without ack: abort to DONE with dmem_req dropped, WB write suppressed (wb_rf_we=0), and mem_err set sticky until rst.
- Without macro: WAIT waits indefinitely; mem_err tied 0; no counter logic.

Test Plan:
- Reset: assert rst 2 cycles during WAIT -> dmem_req=0 next cycle, all outputs 0, FSM IDLE; ack pulse after reset ignored.
- ALU op: ex_valid=1, wa=5, we=1, sel=00, alu_res=0x1234 -> next cycle mem_rf_wa=5, mem_busy=0; cycle after, wb_rf_we=1, wb_rf_wd=0x1234.
- Load, 3-cycle ack: wa=7, sel=01, mem_re=1, addr=0x100.
  - dmem_req=1 for 3 cycles with addr=0x100 and mem_busy=1.
  - dmem_rdata=0xDEADBEEF at ack -> dmem_rd_out=0xDEADBEEF in DONE.
  - WB next: wb_rf_wa=7, wb_rf_wd=0xDEADBEEF.
  - WB holds bubbles during WAIT.
- Store followed by load: store addr=0x40 data=0x55 (ack in first WAIT cycle) -> dmem_we=1 for exactly that cycle.
  - Load enters WAIT directly from DONE.
  - Store never sets wb_rf_we.
- x0 destination: wa=0, we=1, sel=00 -> wb_rf_we=0.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> dmem_req drops after 4 WAIT cycles, mem_err=1 and stays 1, wb_rf_we=0 for that instruction.
